// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - parametrised register/counter bank with one ALU-style write port and two read ports
module reg_bank #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              carry,
  output logic              zero
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_DEC   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             carry_q;
  logic             zero_q;

  logic             wr_in_range;
  logic             rd_a_in_range;
  logic             rd_b_in_range;
  logic             wr_exec;
  logic [WIDTH-1:0] cur_v;
  logic [WIDTH-1:0] wdata_d;
  logic             carry_d;

  assign wr_in_range   = ({1'b0, waddr}   < DEPTH_C);
  assign rd_a_in_range = ({1'b0, raddr_a} < DEPTH_C);
  assign rd_b_in_range = ({1'b0, raddr_b} < DEPTH_C);

  // HOLD and out-of-range targets leave registers and flags untouched.
  assign wr_exec = en && wr_in_range && (op != OP_HOLD);
  assign cur_v   = wr_in_range ? regs_q[waddr] : '0;

  // Result and carry of the requested op on the addressed register's pre-edge value.
  always_comb begin
    wdata_d = cur_v;
    carry_d = carry_q;
    case (op)
      OP_LOAD: begin
        wdata_d = in;
        carry_d = 1'b0;
      end
      OP_CLEAR: begin
        wdata_d = '0;
        carry_d = 1'b0;
      end
      OP_INC: begin
        wdata_d = cur_v + WIDTH'(1);
        carry_d = &cur_v;
      end
      OP_DEC: begin
        wdata_d = cur_v - WIDTH'(1);
        carry_d = (cur_v == '0);
      end
      OP_SHL: begin
        wdata_d = {cur_v[WIDTH-2:0], 1'b0};
        carry_d = cur_v[WIDTH-1];
      end
      OP_SHR: begin
        wdata_d = {1'b0, cur_v[WIDTH-1:1]};
        carry_d = cur_v[0];
      end
      OP_ROL: begin
        wdata_d = {cur_v[WIDTH-2:0], cur_v[WIDTH-1]};
        carry_d = cur_v[WIDTH-1];
      end
      default: begin
        wdata_d = cur_v;
        carry_d = carry_q;
      end
    endcase
  end

  // State update: reset wins over any write; only the addressed register changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (wr_exec) begin
      regs_q[waddr] <= wdata_d;
      carry_q       <= carry_d;
      zero_q        <= (wdata_d == '0);
    end
  end

  // Reads come straight from stored state, so a same-cycle write is not bypassed.
  always_comb begin
    out_a = rd_a_in_range ? regs_q[raddr_a] : '0;
    out_b = rd_b_in_range ? regs_q[raddr_b] : '0;
  end

  assign carry = carry_q;
  assign zero  = zero_q;

endmodule
